// File: rtl/hdmi_cfg_sequencer_if.sv
// Request/response bundle between the HDMI config sequencer and the I2C master.
// The master modport is the side that issues requests (the sequencer).
interface hdmi_cfg_sequencer_if;
  logic       i2c_req;
  logic       i2c_wr;
  logic [7:0] i2c_len;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_saddr;
  logic [7:0] i2c_tx;
  logic [7:0] i2c_rx;
  logic       i2c_de;
  logic       i2c_busy;
  logic       i2c_nack;

  modport master (
    output i2c_req, i2c_wr, i2c_len, i2c_addr, i2c_saddr, i2c_tx,
    input  i2c_rx, i2c_de, i2c_busy, i2c_nack
  );

  modport slave (
    input  i2c_req, i2c_wr, i2c_len, i2c_addr, i2c_saddr, i2c_tx,
    output i2c_rx, i2c_de, i2c_busy, i2c_nack
  );
endinterface

// File: rtl/hdmi_cfg_sequencer.sv
// ADV7611 init-ROM walker: single-byte I2C writes, delay entries, NACK/timeout retry,
// arbitrated manual debug port. Optional write readback check: define CFG_VERIFY_EN.
module hdmi_cfg_sequencer #(
  parameter int unsigned ROM_AW      = 12,
  parameter int unsigned NUM_ENTRIES = 315,
  parameter logic [6:0]  DELAY_ADDR  = 7'h7F,
  parameter int unsigned DELAY_UNIT  = 50000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic                 clk_50,
  input  logic                 reset_n,
  input  logic                 start,
  output logic [ROM_AW-1:0]    rom_addr,
  input  logic [23:0]          rom_data,
  hdmi_cfg_sequencer_if.master i2c,
  input  logic                 man_req,
  input  logic                 man_wr,
  input  logic [6:0]           man_addr,
  input  logic [7:0]           man_saddr,
  input  logic [7:0]           man_wdata,
  output logic                 man_ack,
  output logic [7:0]           man_rdata,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic [ROM_AW-1:0]    err_index,
  output logic [ROM_AW-1:0]    entry_count
);

`ifdef CFG_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, ISSUE, WAIT_BUSY, WAIT_DONE, DELAY, NEXT,
    MAN_ISSUE, MAN_WAIT, DONE, ERROR
  } state_t;

  state_t            r_state, w_state, r_ret, w_ret;
  logic [ROM_AW-1:0] r_rom_addr, w_rom_addr, r_entry_count, w_entry_count;
  logic [ROM_AW-1:0] r_err_index, w_err_index;
  logic              r_cfg_busy, w_cfg_busy, r_cfg_done, w_cfg_done, r_cfg_err, w_cfg_err;
  logic [31:0]       r_retry, w_retry, r_cnt, w_cnt;
  logic              r_req, w_req, r_wr, w_wr, r_seen, w_seen, r_verify, w_verify;
  logic              r_de_d, r_man_ack, w_man_ack;
  logic [6:0]        r_addr, w_addr;
  logic [7:0]        r_saddr, w_saddr, r_tx, w_tx, r_rx, w_rx, r_man_rdata, w_man_rdata;
  logic [7:0]        r_len;
  logic              w_ok, w_fail, w_de_rise;

  assign w_de_rise = i2c.i2c_de & ~r_de_d;

  always_comb begin
    w_state       = r_state;
    w_ret         = r_ret;
    w_rom_addr    = r_rom_addr;
    w_entry_count = r_entry_count;
    w_err_index   = r_err_index;
    w_cfg_busy    = r_cfg_busy;
    w_cfg_done    = r_cfg_done;
    w_cfg_err     = r_cfg_err;
    w_retry       = r_retry;
    w_cnt         = r_cnt;
    w_req         = r_req;
    w_wr          = r_wr;
    w_seen        = r_seen;
    w_verify      = r_verify;
    w_addr        = r_addr;
    w_saddr       = r_saddr;
    w_tx          = r_tx;
    w_rx          = r_rx;
    w_man_rdata   = r_man_rdata;
    w_man_ack     = 1'b0;
    w_ok          = 1'b0;
    w_fail        = 1'b0;

    case (r_state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          w_rom_addr    = '0;
          w_entry_count = '0;
          w_cfg_done    = 1'b0;
          w_cfg_err     = 1'b0;
          w_retry       = '0;
          w_cfg_busy    = 1'b1;
          w_state       = FETCH;
        end else if (man_req) begin
          w_ret   = r_state;
          w_addr  = man_addr;
          w_saddr = man_saddr;
          w_tx    = man_wdata;
          w_wr    = man_wr;
          w_state = MAN_ISSUE;
        end
      end
      FETCH: w_state = DECODE;
      DECODE: begin
        if (rom_data == '1 || 32'(r_rom_addr) == NUM_ENTRIES) begin
          w_cfg_done = 1'b1;
          w_cfg_busy = 1'b0;
          w_state    = DONE;
        end else if (rom_data[23:17] == DELAY_ADDR) begin
          w_cnt   = 32'(rom_data[7:0]) * DELAY_UNIT;
          w_state = DELAY;
        end else begin
          w_addr   = rom_data[23:17];
          w_saddr  = rom_data[15:8];
          w_tx     = rom_data[7:0];
          w_wr     = 1'b1;
          w_verify = 1'b0;
          w_state  = ISSUE;
        end
      end
      ISSUE: begin
        w_req   = 1'b1;
        w_cnt   = '0;
        w_state = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (i2c.i2c_busy) begin
          w_req   = 1'b0;
          w_state = WAIT_DONE;
        end else if (r_cnt >= TIMEOUT - 32'd1) begin
          w_req  = 1'b0;
          w_fail = 1'b1;
        end else begin
          w_cnt = r_cnt + 32'd1;
        end
      end
      WAIT_DONE: begin
        if (r_verify && w_de_rise) w_rx = i2c.i2c_rx;
        if (!i2c.i2c_busy) begin
          if (i2c.i2c_nack) w_fail = 1'b1;
          else              w_ok   = 1'b1;
        end
      end
      DELAY: begin
        if (r_cnt == '0) w_state = NEXT;
        else             w_cnt   = r_cnt - 32'd1;
      end
      NEXT: begin
        w_rom_addr = r_rom_addr + ROM_AW'(1);
        w_retry    = '0;
        w_state    = FETCH;
      end
      MAN_ISSUE: begin
        w_req   = 1'b1;
        w_cnt   = '0;
        w_seen  = 1'b0;
        w_state = MAN_WAIT;
      end
      MAN_WAIT: begin
        // A timed-out manual access still acks so the requester never stalls.
        if (!r_seen) begin
          if (i2c.i2c_busy) begin
            w_seen = 1'b1;
            w_req  = 1'b0;
          end else if (r_cnt >= TIMEOUT - 32'd1) begin
            w_req     = 1'b0;
            w_man_ack = 1'b1;
            w_state   = r_ret;
          end else begin
            w_cnt = r_cnt + 32'd1;
          end
        end else if (!i2c.i2c_busy) begin
          w_man_ack = 1'b1;
          w_state   = r_ret;
        end
        if (!r_wr && w_de_rise) w_man_rdata = i2c.i2c_rx;
      end
      default: w_state = IDLE;
    endcase

    // Readback pass: a clean write turns into a read; a mismatching read behaves as a NACK.
    if (VERIFY_EN && w_ok) begin
      if (!r_verify) begin
        w_ok     = 1'b0;
        w_verify = 1'b1;
        w_wr     = 1'b0;
        w_state  = ISSUE;
      end else if (w_rx != r_tx) begin
        w_ok   = 1'b0;
        w_fail = 1'b1;
      end
    end

    if (w_ok) begin
      w_entry_count = r_entry_count + ROM_AW'(1);
      w_state       = NEXT;
    end
    if (w_fail) begin
      if (r_retry < MAX_RETRY) begin
        w_retry  = r_retry + 32'd1;
        w_wr     = 1'b1;
        w_verify = 1'b0;
        w_state  = ISSUE;
      end else begin
        w_err_index = r_rom_addr;
        w_cfg_err   = 1'b1;
        w_cfg_busy  = 1'b0;
        w_state     = ERROR;
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_ret         <= IDLE;
      r_rom_addr    <= '0;
      r_entry_count <= '0;
      r_err_index   <= '0;
      r_cfg_busy    <= 1'b0;
      r_cfg_done    <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_retry       <= '0;
      r_cnt         <= '0;
      r_req         <= 1'b0;
      r_wr          <= 1'b0;
      r_seen        <= 1'b0;
      r_verify      <= 1'b0;
      r_addr        <= '0;
      r_saddr       <= '0;
      r_tx          <= '0;
      r_rx          <= '0;
      r_man_rdata   <= '0;
      r_man_ack     <= 1'b0;
      r_de_d        <= 1'b0;
      r_len         <= '0;
    end else begin
      r_state       <= w_state;
      r_ret         <= w_ret;
      r_rom_addr    <= w_rom_addr;
      r_entry_count <= w_entry_count;
      r_err_index   <= w_err_index;
      r_cfg_busy    <= w_cfg_busy;
      r_cfg_done    <= w_cfg_done;
      r_cfg_err     <= w_cfg_err;
      r_retry       <= w_retry;
      r_cnt         <= w_cnt;
      r_req         <= w_req;
      r_wr          <= w_wr;
      r_seen        <= w_seen;
      r_verify      <= w_verify;
      r_addr        <= w_addr;
      r_saddr       <= w_saddr;
      r_tx          <= w_tx;
      r_rx          <= w_rx;
      r_man_rdata   <= w_man_rdata;
      r_man_ack     <= w_man_ack;
      r_de_d        <= i2c.i2c_de;
      r_len         <= 8'd1;
    end
  end

  assign rom_addr      = r_rom_addr;
  assign i2c.i2c_req   = r_req;
  assign i2c.i2c_wr    = r_wr;
  assign i2c.i2c_len   = r_len;
  assign i2c.i2c_addr  = r_addr;
  assign i2c.i2c_saddr = r_saddr;
  assign i2c.i2c_tx    = r_tx;
  assign man_ack       = r_man_ack;
  assign man_rdata     = r_man_rdata;
  assign cfg_busy      = r_cfg_busy;
  assign cfg_done      = r_cfg_done;
  assign cfg_err       = r_cfg_err;
  assign err_index     = r_err_index;
  assign entry_count   = r_entry_count;

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// Directed bench for hdmi_cfg_sequencer: ROM model, I2C master model with NACK/mute
// controls, and per-scenario tasks with inline checks.
module tb_hdmi_cfg_sequencer;
  localparam int unsigned AW = 12;
  localparam int unsigned DU = 100;
  localparam int unsigned TO = 64;

  logic          clk_50 = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [23:0]   rom_data;
  logic          man_req = 1'b0;
  logic          man_wr = 1'b0;
  logic [6:0]    man_addr = '0;
  logic [7:0]    man_saddr = '0;
  logic [7:0]    man_wdata = '0;
  logic          man_ack;
  logic [7:0]    man_rdata;
  logic          cfg_busy, cfg_done, cfg_err;
  logic [AW-1:0] err_index, entry_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] rom [16];
  int unsigned cyc = 0;

  // I2C master model log and controls
  int          n_txn = 0;
  logic [6:0]  t_addr  [16];
  logic [7:0]  t_saddr [16];
  logic [7:0]  t_tx    [16];
  logic [7:0]  t_len   [16];
  logic        t_wr    [16];
  logic        t_done  [16];
  int unsigned t_cyc   [16];
  bit          bfm_mute = 1'b0;
  bit          bfm_idle = 1'b1;
  bit          nack_stuck = 1'b0;
  int          nack_left = 0;
  logic [7:0]  nack_saddr = 8'hFF;

  hdmi_cfg_sequencer_if bus();

  hdmi_cfg_sequencer #(
    .ROM_AW(AW), .NUM_ENTRIES(315), .DELAY_ADDR(7'h7F),
    .DELAY_UNIT(DU), .MAX_RETRY(3), .TIMEOUT(TO)
  ) dut (
    .clk_50(clk_50), .reset_n(reset_n), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data), .i2c(bus),
    .man_req(man_req), .man_wr(man_wr), .man_addr(man_addr),
    .man_saddr(man_saddr), .man_wdata(man_wdata), .man_ack(man_ack),
    .man_rdata(man_rdata), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .err_index(err_index), .entry_count(entry_count)
  );

  always #10 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;
  always @(posedge clk_50) rom_data <= (rom_addr < AW'(16)) ? rom[rom_addr[3:0]] : 24'hFFFFFF;

  initial begin
    logic       cur_wr;
    logic [6:0] cur_addr;
    logic [7:0] cur_saddr;
    bus.i2c_busy = 1'b0;
    bus.i2c_de   = 1'b0;
    bus.i2c_nack = 1'b0;
    bus.i2c_rx   = '0;
    forever begin
      @(posedge clk_50); #1;
      if (bus.i2c_req === 1'b1 && !bfm_mute) begin
        bfm_idle  = 1'b0;
        cur_wr    = bus.i2c_wr;
        cur_addr  = bus.i2c_addr;
        cur_saddr = bus.i2c_saddr;
        if (n_txn < 16) begin
          t_addr[n_txn]  = bus.i2c_addr;
          t_saddr[n_txn] = bus.i2c_saddr;
          t_tx[n_txn]    = bus.i2c_tx;
          t_len[n_txn]   = bus.i2c_len;
          t_wr[n_txn]    = bus.i2c_wr;
          t_done[n_txn]  = cfg_done;
          t_cyc[n_txn]   = cyc;
        end
        n_txn++;
        repeat (2) @(posedge clk_50);
        #1 bus.i2c_busy = 1'b1;
        repeat (3) @(posedge clk_50);
        #1;
        if (!cur_wr) bus.i2c_rx = (cur_addr == 7'h4C && cur_saddr == 8'h00) ? 8'h20 : 8'hA5;
        bus.i2c_de = 1'b1;
        @(posedge clk_50);
        #1 bus.i2c_de = 1'b0;
        repeat (2) @(posedge clk_50);
        #1;
        if (cur_saddr == nack_saddr && (nack_stuck || nack_left > 0)) begin
          bus.i2c_nack = 1'b1;
          if (nack_left > 0) nack_left--;
        end
        bus.i2c_busy = 1'b0;
        @(posedge clk_50);
        #1 bus.i2c_nack = 1'b0;
        bfm_idle = 1'b1;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [80:0] all_outs();
    return {rom_addr, bus.i2c_req, bus.i2c_wr, bus.i2c_len, bus.i2c_addr, bus.i2c_saddr,
            bus.i2c_tx, man_ack, man_rdata, cfg_busy, cfg_done, cfg_err, err_index, entry_count};
  endfunction

  task automatic load_basic();
    for (int i = 0; i < 16; i++) rom[i] = 24'hFFFFFF;
    rom[0] = 24'h98F480;
    rom[1] = 24'h98F57C;
  endtask

  task automatic pulse_start();
    @(negedge clk_50); start = 1'b1;
    @(negedge clk_50); start = 1'b0;
  endtask

  task automatic wait_end(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_50);
      if (cfg_done || cfg_err) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ack(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_50);
      if (man_ack) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(negedge clk_50);
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    reset_n = 1'b1;
    @(negedge clk_50);
    n_checks++;
    if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", cfg_busy); end
  endtask

  task automatic test_basic();
    bit ok;
    load_basic();
    n_txn = 0;
    pulse_start();
    n_checks++;
    if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", cfg_busy); end
    wait_end(3000, ok);
    n_checks++;
    if (!ok || cfg_done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", cfg_done); end
    n_checks++;
    if (n_txn !== 2) begin n_fail++; $display("FAIL basic_txns: got %0d expected 2", n_txn); end
    n_checks++;
    if ({t_addr[0], t_wr[0], t_saddr[0], t_tx[0], t_len[0]} !== {7'h4C, 1'b1, 8'hF4, 8'h80, 8'd1}) begin
      n_fail++; $display("FAIL basic_txn0: got %h/%b/%h/%h/%h expected 4c/1/f4/80/01",
                         t_addr[0], t_wr[0], t_saddr[0], t_tx[0], t_len[0]);
    end
    n_checks++;
    if ({t_addr[1], t_wr[1], t_saddr[1], t_tx[1]} !== {7'h4C, 1'b1, 8'hF5, 8'h7C}) begin
      n_fail++; $display("FAIL basic_txn1: got %h/%b/%h/%h expected 4c/1/f5/7c",
                         t_addr[1], t_wr[1], t_saddr[1], t_tx[1]);
    end
    n_checks++;
    if (entry_count !== AW'(2)) begin n_fail++; $display("FAIL basic_count: got %0d expected 2", entry_count); end
    n_checks++;
    if ({cfg_busy, cfg_err} !== 2'b00) begin n_fail++; $display("FAIL basic_flags: got %b%b expected 00", cfg_busy, cfg_err); end
  endtask

  task automatic test_delay();
    bit ok;
    int unsigned gap;
    load_basic();
    rom[1] = 24'hFE0005;
    rom[2] = 24'h98F57C;
    n_txn = 0;
    pulse_start();
    wait_end(3000, ok);
    n_checks++;
    if (!ok || cfg_done !== 1'b1) begin n_fail++; $display("FAIL delay_done: got %b expected 1", cfg_done); end
    n_checks++;
    if (n_txn !== 2) begin n_fail++; $display("FAIL delay_txns: got %0d expected 2", n_txn); end
    gap = t_cyc[1] - t_cyc[0];
    n_checks++;
    if (gap < 5 * DU || gap > 5 * DU + 20) begin
      n_fail++; $display("FAIL delay_gap: got %0d expected %0d..%0d", gap, 5 * DU, 5 * DU + 20);
    end
    n_checks++;
    if (entry_count !== AW'(2)) begin n_fail++; $display("FAIL delay_count: got %0d expected 2", entry_count); end
  endtask

  task automatic test_retry();
    bit ok;
    load_basic();
    n_txn = 0;
    nack_saddr = 8'hF5;
    nack_left  = 2;
    pulse_start();
    wait_end(3000, ok);
    n_checks++;
    if (!ok || {cfg_done, cfg_err} !== 2'b10) begin
      n_fail++; $display("FAIL retry_flags: got %b%b expected 10", cfg_done, cfg_err);
    end
    n_checks++;
    if (n_txn !== 4) begin n_fail++; $display("FAIL retry_txns: got %0d expected 4", n_txn); end
    n_checks++;
    if (t_saddr[3] !== 8'hF5) begin n_fail++; $display("FAIL retry_saddr: got %h expected f5", t_saddr[3]); end
    n_checks++;
    if (entry_count !== AW'(2)) begin n_fail++; $display("FAIL retry_count: got %0d expected 2", entry_count); end
  endtask

  task automatic test_stuck_nack();
    bit ok;
    load_basic();
    n_txn = 0;
    nack_saddr = 8'hF5;
    nack_stuck = 1'b1;
    pulse_start();
    wait_end(3000, ok);
    nack_stuck = 1'b0;
    n_checks++;
    if (!ok || {cfg_done, cfg_err, cfg_busy} !== 3'b010) begin
      n_fail++; $display("FAIL stuck_flags: got %b%b%b expected 010", cfg_done, cfg_err, cfg_busy);
    end
    n_checks++;
    if (n_txn !== 5) begin n_fail++; $display("FAIL stuck_txns: got %0d expected 5", n_txn); end
    n_checks++;
    if (err_index !== AW'(1)) begin n_fail++; $display("FAIL stuck_index: got %0d expected 1", err_index); end
    n_checks++;
    if (entry_count !== AW'(1)) begin n_fail++; $display("FAIL stuck_count: got %0d expected 1", entry_count); end
  endtask

  task automatic test_manual_read();
    bit ok;
    load_basic();
    n_txn = 0;
    @(negedge clk_50);
    man_wr = 1'b0; man_addr = 7'h4C; man_saddr = 8'h00; man_wdata = 8'h00;
    man_req = 1'b1;
    start = 1'b1;
    @(negedge clk_50);
    start = 1'b0;
    n_checks++;
    if ({cfg_busy, cfg_err} !== 2'b10) begin n_fail++; $display("FAIL man_start_wins: got %b%b expected 10", cfg_busy, cfg_err); end
    wait_ack(3000, ok);
    man_req = 1'b0;
    n_checks++;
    if (!ok || cfg_done !== 1'b1) begin n_fail++; $display("FAIL man_ack_after_done: got %b/%b expected 1/1", ok, cfg_done); end
    n_checks++;
    if (n_txn !== 3) begin n_fail++; $display("FAIL man_txns: got %0d expected 3", n_txn); end
    n_checks++;
    if ({t_wr[2], t_addr[2], t_saddr[2], t_done[2]} !== {1'b0, 7'h4C, 8'h00, 1'b1}) begin
      n_fail++; $display("FAIL man_txn: got %b/%h/%h/%b expected 0/4c/00/1", t_wr[2], t_addr[2], t_saddr[2], t_done[2]);
    end
    n_checks++;
    if (man_rdata !== 8'h20) begin n_fail++; $display("FAIL man_rdata: got %h expected 20", man_rdata); end
    @(negedge clk_50);
    n_checks++;
    if (man_ack !== 1'b0) begin n_fail++; $display("FAIL man_ack_width: got %b expected 0", man_ack); end
    n_checks++;
    if ({cfg_done, cfg_err, entry_count} !== {1'b1, 1'b0, AW'(2)}) begin
      n_fail++; $display("FAIL man_status_kept: got %b%b/%0d expected 10/2", cfg_done, cfg_err, entry_count);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int unsigned c0;
    bfm_mute = 1'b1;
    @(negedge clk_50);
    man_wr = 1'b1; man_addr = 7'h4C; man_saddr = 8'h10; man_wdata = 8'h55;
    man_req = 1'b1;
    c0 = cyc;
    wait_ack(400, ok);
    man_req = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL timeout_ack: got 0 expected 1"); end
    n_checks++;
    if (cyc - c0 < TO || cyc - c0 > TO + 8) begin
      n_fail++; $display("FAIL timeout_len: got %0d expected %0d..%0d", cyc - c0, TO, TO + 8);
    end
    n_checks++;
    if ({bus.i2c_req, man_rdata, cfg_done} !== {1'b0, 8'h20, 1'b1}) begin
      n_fail++; $display("FAIL timeout_state: got %b/%h/%b expected 0/20/1", bus.i2c_req, man_rdata, cfg_done);
    end
    @(negedge clk_50);
    bfm_mute = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    load_basic();
    n_txn = 0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_50);
      if (bus.i2c_busy) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rmid_busy_seen: got 0 expected 1"); end
    @(negedge clk_50);
    reset_n = 1'b0;
    @(negedge clk_50);
    n_checks++;
    if (all_outs() !== '0) begin n_fail++; $display("FAIL rmid_outputs: got %h expected 0", all_outs()); end
    reset_n = 1'b1;
    for (int i = 0; i < 100 && !bfm_idle; i++) @(negedge clk_50);
    n_txn = 0;
    pulse_start();
    wait_end(3000, ok);
    n_checks++;
    if (!ok || n_txn !== 2 || t_saddr[0] !== 8'hF4) begin
      n_fail++; $display("FAIL rmid_rerun: got done=%b txns=%0d saddr0=%h expected 1/2/f4", ok, n_txn, t_saddr[0]);
    end
    n_checks++;
    if (entry_count !== AW'(2)) begin n_fail++; $display("FAIL rmid_count: got %0d expected 2", entry_count); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 24'hFFFFFF;
    test_reset();
    test_basic();
    test_delay();
    test_retry();
    test_stuck_nack();
    test_manual_read();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hdmi_cfg_sequencer.md
Name: hdmi_cfg_sequencer

Overview:
Parametrised I2C configuration sequencer for the ADV7611 HDMI receiver front end. Walks a 24-bit-entry init ROM and issues single-byte I2C writes through the existing I2C master. Adds end-marker and delay entries, NACK/timeout retry, error reporting, and an arbitrated manual read/write port for debug switches and keys. Sits between the init ROM, the I2C master and the board-level top.

Parameters:
ROM_AW, 12, ROM address width; also width of the index and count outputs
NUM_ENTRIES, 315, hard upper bound on entries walked
DELAY_ADDR, 7'h7F, device address that marks a delay entry
DELAY_UNIT, 50000, clk_50 cycles per delay-entry data unit (1 ms)
MAX_RETRY, 3, re-issues allowed per entry after the first attempt
TIMEOUT, 4096, cycles to wait for i2c_busy to rise after a request

Ports:
clk_50  in  1  system clock, 50 MHz
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins or restarts the sequence
rom_addr  out  ROM_AW  init ROM address; ROM read latency is 1 cycle
rom_data  in  24  entry {dev_addr[23:17], unused[16], subaddr[15:8], data[7:0]}
i2c_req  out  1  request to I2C master
i2c_wr  out  1  1 = write, 0 = read
i2c_len  out  8  transfer length in bytes; always 1
i2c_addr  out  7  device address
i2c_saddr  out  8  subaddress
i2c_tx  out  8  write byte
i2c_rx  in  8  read byte
i2c_de  in  1  data-processed strobe from master
i2c_busy  in  1  master busy
i2c_nack  in  1  master NACK flag; valid on the busy falling edge
man_req  in  1  manual access request, level
man_wr  in  1  manual write(1) or read(0)
man_addr  in  7  manual device address
man_saddr  in  8  manual subaddress
man_wdata  in  8  manual write byte
man_ack  out  1  one-cycle pulse when the manual transfer completes
man_rdata  out  8  manual read result, held until the next read
cfg_busy  out  1  sequence in progress
cfg_done  out  1  sequence completed without error
cfg_err  out  1  entry failed after retries
err_index  out  ROM_AW  ROM index of the failing entry
entry_count  out  ROM_AW  number of entries written successfully

Behaviour:
- Reset (reset_n low at clk_50 edge): state IDLE; every output is 0. A reset taken mid-transfer drops i2c_req on the next cycle and does not wait for the master.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_BUSY, WAIT_DONE, DELAY, NEXT, MAN_ISSUE, MAN_WAIT, DONE, ERROR.
- start in IDLE, DONE or ERROR: clear rom_addr, entry_count, cfg_done, cfg_err and the retry count; go to FETCH; cfg_busy=1. start in any other state is ignored.
- FETCH: drive rom_addr. DECODE (next cycle): rom_data is valid.
  - rom_data == 24'hFFFFFF, or rom_addr == NUM_ENTRIES: go to DONE.
  - dev_addr == DELAY_ADDR: go to DELAY. Load the counter with data*DELAY_UNIT; data==0 means zero wait.
  - Otherwise latch addr, saddr and tx; i2c_wr=1; go to ISSUE.
- Request handshake:
  - ISSUE asserts i2c_req and holds it until i2c_busy is sampled 1 (WAIT_BUSY), then deasserts it the same cycle busy is seen.
  - If busy does not rise within TIMEOUT cycles of i2c_req assertion, treat the attempt as a NACK.
- Completion: the first cycle with i2c_busy 1->0.
  - i2c_nack=0: increment entry_count, go to NEXT.
  - i2c_nack=1: retry count < MAX_RETRY -> increment it and return to ISSUE; otherwise err_index=rom_addr, cfg_err=1, go to ERROR.
- NEXT: rom_addr+1, clear the retry count, go to FETCH. rom_addr does not wrap; NUM_ENTRIES bounds it.
- DONE: cfg_done=1, cfg_busy=0. ERROR: cfg_err=1, cfg_busy=0; the sequence halts.
- Manual port:
  - man_req is accepted only in IDLE, DONE or ERROR. While the sequence runs it stays pending and is never dropped.
  - Uses the same handshake and timeout, with no retry. On completion pulse man_ack for 1 cycle. On a read, capture man_rdata from i2c_rx at the i2c_de rising edge.
  - Afterwards return to the state it came from; cfg_done and cfg_err are unchanged.
  - man_req together with start in the same cycle: start wins; the manual request waits until the sequence finishes.

Optional Feature:
CFG_VERIFY_EN
- Defined: after each successful entry write, issue a read of the same addr/saddr.
  - Mismatch with the written data counts as a NACK, so it consumes a retry and re-issues the write.
  - Write-only registers are not special-cased; the ROM must not contain them.
- Undefined: no readback; writes complete on busy falling.

Test Plan:
- ROM holds 3 entries {98,F4,80},{98,F5,7C},FFFFFF; pulse start -> exactly 2 writes with saddr F4/F5 and data 80/7C; cfg_done=1; entry_count=2.
- Entry {FE,00,05} (dev 7F) -> 250000 cycles between the neighbouring writes' i2c_req; no I2C transaction for the delay entry.
- i2c_nack=1 on the first 2 attempts of entry 1 -> 3 issues, then success; entry_count increments once.
- i2c_nack stuck 1 with MAX_RETRY=3 -> 4 issues; cfg_err=1; err_index=1; cfg_busy=0.
- man_req read addr 0x4C saddr 0x00 during the sequence -> held off until cfg_done; then one read; man_ack pulses; man_rdata equals the model value 0x20.
- reset_n low while in WAIT_DONE -> next cycle all outputs 0; a later start reruns from index 0.
